// File: rtl/pc_gen_pkg.sv
// Shared fetch-side definitions: PC FSM states, default geometry
// and handshake polarity constants.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  localparam int          DEF_ADDR_W    = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0;
  localparam int          DEF_STEP      = 4;

  localparam logic Branch = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/redirect_buf.sv
// One-entry branch target buffer with valid bit.
// Clear wins over load so a flush always drops the entry.
module redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] tgt_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] tgt_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  always_comb begin
    valid_d = valid_q;
    tgt_d   = tgt_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      tgt_d   = tgt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tgt_q   <= tgt_d;
    end
  end

  assign valid_o = valid_q;
  assign tgt_o   = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with req/gnt handshake,
// flush/branch redirect priority and a pending-branch buffer.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int              STEP      = DEF_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              fetch_gnt_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o,
  output logic              pend_o
);

  localparam logic [ADDR_W-1:0] LOW_M = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(STEP);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mis_q, mis_d;

  logic              adv;
  logic              br;
  logic              ld;
  logic [ADDR_W-1:0] raw;
  logic              buf_ld, buf_clr, buf_vld;
  logic [ADDR_W-1:0] buf_tgt;

  redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_ld),
    .clr_i   (buf_clr),
    .tgt_i   (branch_pc_i),
    .valid_o (buf_vld),
    .tgt_o   (buf_tgt)
  );

  assign fetch_req_o = (state_q != ST_HOLD);
  assign adv = fetch_req_o & fetch_gnt_i
             & (stall_i == NoStop);
  assign br  = (branch_i == Branch);

  always_comb begin
    state_d = (state_q == ST_HOLD) ? ST_RUN : state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    ld      = 1'b0;
    raw     = '0;
    buf_ld  = 1'b0;
    buf_clr = 1'b0;
    priority case (1'b1)
      flush_i: begin
        ld      = 1'b1;
        raw     = flush_pc_i;
        buf_clr = 1'b1;
        state_d = ST_RUN;
      end
      br && adv: begin
        ld      = 1'b1;
        raw     = branch_pc_i;
        buf_clr = 1'b1;
        state_d = ST_RUN;
      end
      br: begin
        buf_ld  = 1'b1;
        state_d = ST_PEND;
      end
      buf_vld && adv: begin
        ld      = 1'b1;
        raw     = buf_tgt;
        buf_clr = 1'b1;
        state_d = ST_RUN;
      end
      adv: begin
        pc_d = pc_q + INC;
      end
      default: begin
      end
    endcase
    // Targets are forced onto the fetch grid; the pulse flags it.
    if (ld) begin
      pc_d  = raw & ~LOW_M;
      mis_d = |(raw & LOW_M);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      pc_q    <= RESET_VEC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = mis_q;
  assign pend_o     = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance and an 8-bit
// wrap instance, each shadowed by a behavioural model.
module tb_pc_gen;

  typedef struct {
    logic [31:0] pc;
    bit          req;
    bit          pv;
    logic [31:0] pt;
    bit          mis;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic        a_rst = 1'b1, a_stall = 1'b0, a_flush = 1'b0;
  logic        a_br = 1'b0, a_gnt = 1'b1;
  logic [31:0] a_fpc = '0, a_bpc = '0;
  logic        a_req, a_mis, a_pend;
  logic [31:0] a_pc;

  logic        b_rst = 1'b1, b_stall = 1'b0, b_flush = 1'b0;
  logic        b_br = 1'b0, b_gnt = 1'b1;
  logic [7:0]  b_fpc = '0, b_bpc = '0;
  logic        b_req, b_mis, b_pend;
  logic [7:0]  b_pc;

  pc_gen #(
    .ADDR_W    (32),
    .RESET_VEC (32'h100),
    .STEP      (4)
  ) dut_a (
    .clk         (clk),
    .rst         (a_rst),
    .stall_i     (a_stall),
    .flush_i     (a_flush),
    .flush_pc_i  (a_fpc),
    .branch_i    (a_br),
    .branch_pc_i (a_bpc),
    .fetch_gnt_i (a_gnt),
    .fetch_req_o (a_req),
    .pc_o        (a_pc),
    .misalign_o  (a_mis),
    .pend_o      (a_pend)
  );

  pc_gen #(
    .ADDR_W    (8),
    .RESET_VEC (8'hF4),
    .STEP      (4)
  ) dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .stall_i     (b_stall),
    .flush_i     (b_flush),
    .flush_pc_i  (b_fpc),
    .branch_i    (b_br),
    .branch_pc_i (b_bpc),
    .fetch_gnt_i (b_gnt),
    .fetch_req_o (b_req),
    .pc_o        (b_pc),
    .misalign_o  (b_mis),
    .pend_o      (b_pend)
  );

  function automatic mdl_t step_m(
    input mdl_t        s,
    input bit          rst,
    input bit          stall,
    input bit          flush,
    input logic [31:0] fpc,
    input bit          br,
    input logic [31:0] bpc,
    input bit          gnt,
    input logic [31:0] mask,
    input logic [31:0] rv
  );
    mdl_t        n;
    bit          adv;
    bit          ld;
    logic [31:0] tgt;
    n   = s;
    ld  = 1'b0;
    tgt = '0;
    if (rst) begin
      n.pc  = rv;
      n.req = 1'b0;
      n.pv  = 1'b0;
      n.pt  = '0;
      n.mis = 1'b0;
      return n;
    end
    adv   = s.req && gnt && !stall;
    n.mis = 1'b0;
    n.req = 1'b1;
    if (flush) begin
      ld = 1'b1; tgt = fpc; n.pv = 1'b0;
    end else if (br && adv) begin
      ld = 1'b1; tgt = bpc; n.pv = 1'b0;
    end else if (br) begin
      n.pv = 1'b1; n.pt = bpc;
    end else if (s.pv && adv) begin
      ld = 1'b1; tgt = s.pt; n.pv = 1'b0;
    end else if (adv) begin
      n.pc = (s.pc + 32'd4) & mask;
    end
    if (ld) begin
      n.pc  = tgt & mask & ~32'd3;
      n.mis = (tgt % 4) != 0;
    end
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk) begin
    ma <= step_m(ma, a_rst, a_stall, a_flush, a_fpc,
                 a_br, a_bpc, a_gnt, 32'hFFFF_FFFF,
                 32'h100);
    mb <= step_m(mb, b_rst, b_stall, b_flush,
                 {24'h0, b_fpc}, b_br, {24'h0, b_bpc},
                 b_gnt, 32'h0000_00FF, 32'hF4);
    started <= 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("a_pc_m",   a_pc,           ma.pc);
      chk("a_req_m",  {31'h0, a_req}, {31'h0, ma.req});
      chk("a_mis_m",  {31'h0, a_mis}, {31'h0, ma.mis});
      chk("a_pend_m", {31'h0, a_pend}, {31'h0, ma.pv});
      chk("b_pc_m",   {24'h0, b_pc},  mb.pc);
      chk("b_req_m",  {31'h0, b_req}, {31'h0, mb.req});
      chk("b_mis_m",  {31'h0, b_mis}, {31'h0, mb.mis});
      chk("b_pend_m", {31'h0, b_pend}, {31'h0, mb.pv});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk("a_rst_pc",  a_pc, 32'h100);
    chk("a_rst_req", {31'h0, a_req}, 32'h0);
    chk("a_rst_pnd", {31'h0, a_pend}, 32'h0);
    chk("a_rst_mis", {31'h0, a_mis}, 32'h0);

    a_rst = 1'b0;
    cyc(1);
    chk("a_first_req", {31'h0, a_req}, 32'h1);
    chk("a_first_pc",  a_pc, 32'h100);
    cyc(1);
    chk("a_pc_104", a_pc, 32'h104);
    cyc(1);
    chk("a_pc_108", a_pc, 32'h108);

    a_stall = 1'b1; a_br = 1'b1; a_bpc = 32'h2000;
    cyc(1);
    chk("a_pend_set", {31'h0, a_pend}, 32'h1);
    chk("a_pend_hold", a_pc, 32'h108);
    a_br = 1'b0;
    cyc(1);
    chk("a_pend_hold2", a_pc, 32'h108);
    a_stall = 1'b0;
    cyc(1);
    chk("a_pend_apply", a_pc, 32'h2000);
    chk("a_pend_clr", {31'h0, a_pend}, 32'h0);

    a_stall = 1'b1; a_flush = 1'b1; a_fpc = 32'h80;
    a_br = 1'b1; a_bpc = 32'h3000;
    cyc(1);
    chk("a_flush_win", a_pc, 32'h80);
    chk("a_flush_nopend", {31'h0, a_pend}, 32'h0);
    a_flush = 1'b0; a_br = 1'b0; a_stall = 1'b0;
    cyc(1);
    chk("a_after_flush", a_pc, 32'h84);

    a_br = 1'b1; a_bpc = 32'h2002;
    cyc(1);
    chk("a_mis_pc", a_pc, 32'h2000);
    chk("a_mis_hi", {31'h0, a_mis}, 32'h1);
    a_br = 1'b0;
    cyc(1);
    chk("a_mis_lo", {31'h0, a_mis}, 32'h0);
    chk("a_mis_next", a_pc, 32'h2004);

    a_stall = 1'b1; a_br = 1'b1; a_bpc = 32'h4006;
    cyc(1);
    chk("a_bufmis_quiet", {31'h0, a_mis}, 32'h0);
    a_br = 1'b0; a_stall = 1'b0;
    cyc(1);
    chk("a_bufmis_pc", a_pc, 32'h4004);
    chk("a_bufmis_hi", {31'h0, a_mis}, 32'h1);
    cyc(1);

    a_gnt = 1'b0; a_br = 1'b1; a_bpc = 32'h5000;
    cyc(1);
    a_bpc = 32'h6000;
    cyc(1);
    a_br = 1'b0; a_gnt = 1'b1;
    cyc(1);
    chk("a_newer_wins", a_pc, 32'h6000);

    a_stall = 1'b1; a_br = 1'b1; a_bpc = 32'h7000;
    cyc(1);
    a_br = 1'b0; a_rst = 1'b1;
    cyc(1);
    chk("a_mid_rst_pc", a_pc, 32'h100);
    chk("a_mid_rst_pnd", {31'h0, a_pend}, 32'h0);
    a_rst = 1'b0; a_stall = 1'b0;
    cyc(2);
    chk("a_resume", a_pc, 32'h104);

    a_rst = 1'b1;
    cyc(1);
    a_rst = 1'b0; a_flush = 1'b1; a_fpc = 32'h91;
    cyc(1);
    chk("a_hold_flush", a_pc, 32'h90);
    a_flush = 1'b0;
    cyc(1);

    a_stall = 1'b1; a_br = 1'b1; a_bpc = 32'h8000;
    cyc(1);
    a_br = 1'b0; a_stall = 1'b0;
    a_flush = 1'b1; a_fpc = 32'hA0;
    cyc(1);
    chk("a_flush_vs_pend", a_pc, 32'hA0);
    a_flush = 1'b0;
    cyc(1);
    chk("a_flush_vs_pend2", a_pc, 32'hA4);

    chk("b_rst_pc", {24'h0, b_pc}, 32'hF4);
    chk("b_rst_req", {31'h0, b_req}, 32'h0);
    b_rst = 1'b0;
    cyc(3);
    chk("b_pc_fc", {24'h0, b_pc}, 32'hFC);
    cyc(1);
    chk("b_wrap", {24'h0, b_pc}, 32'h00);
    b_gnt = 1'b0;
    cyc(3);
    chk("b_gap_hold", {24'h0, b_pc}, 32'h00);
    b_gnt = 1'b1;
    cyc(1);
    chk("b_after_gap", {24'h0, b_pc}, 32'h04);
    b_flush = 1'b1; b_fpc = 8'h31;
    cyc(1);
    chk("b_flush_al", {24'h0, b_pc}, 32'h30);
    b_flush = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It is the successor of the single-width PC register. It drives the instruction-fetch address with a request/grant handshake to instruction memory, and applies flush and branch redirects with fixed priority. A branch that arrives while fetch cannot advance is held in a one-entry pending-redirect buffer rather than lost.

## Interface
- ADDR_W, 32, PC / address width in bits
- RESET_VEC, 0, PC value loaded by reset
- STEP, 4, byte increment per sequential fetch; power of two, ≥1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- stall_i  in  1  stage-0 stall from the pipeline controller; 1 = hold PC
- flush_i  in  1  exception/flush redirect; overrides everything
- flush_pc_i  in  ADDR_W  flush target
- branch_i  in  1  branch-taken redirect from decode, single-cycle pulse
- branch_pc_i  in  ADDR_W  branch target
- fetch_gnt_i  in  1  instruction memory accepts the current pc_o
- fetch_req_o  out  1  fetch request; this block's chip-enable
- pc_o  out  ADDR_W  current fetch address, registered
- misalign_o  out  1  one-cycle pulse: an accepted redirect target was not STEP-aligned
- pend_o  out  1  a branch redirect is buffered (debug/perf)

## Operation
- Advance condition: adv = fetch_req_o & fetch_gnt_i & ~stall_i.
- States: HOLD (after reset, req=0), RUN (req=1, no pending), PEND (req=1, pending branch held).
- HOLD → RUN unconditionally on the next cycle. pc_o stays RESET_VEC in HOLD.
- Next-PC priority, every cycle out of reset:
  1. flush_i: pc_o ← flush_pc_i regardless of stall, grant or state; pending buffer cleared; → RUN.
  2. branch_i & adv: pc_o ← branch_pc_i; pending buffer cleared; → RUN.
  3. branch_i & ~adv: branch_pc_i written to the pending buffer (a newer branch overwrites an older one); → PEND; pc_o unchanged.
  4. PEND & adv: pc_o ← buffered target; → RUN.
  5. RUN & adv: pc_o ← pc_o + STEP, modulo 2^ADDR_W (wraps from max to 0).
  6. Otherwise hold.
- flush_i in HOLD loads flush_pc_i and goes to RUN.
- Alignment:
  - Any redirect target (flush, branch, or buffered) has its low log2(STEP) bits cleared before loading.
  - misalign_o pulses in the cycle after a load whose raw target had nonzero low bits. It does not pulse when the target is buffered, only when it is loaded into pc_o.
- fetch_req_o = 0 in HOLD, 1 in RUN and PEND.

## Timing
- Reset values: pc_o = RESET_VEC, fetch_req_o = 0, misalign_o = 0, pend_o = 0, state HOLD, pending buffer = 0.
- rst is sampled at the edge; rst high mid-operation discards any pending branch and returns to HOLD in one cycle.
- First rising edge after rst falls: fetch_req_o = 1, pc_o = RESET_VEC. The first sequential increment occurs on the first adv.
- Redirect latency: flush_i or branch_i with adv in cycle t gives the new pc_o in cycle t+1.
- Buffered branch: applied on the edge ending the first adv cycle, so pc_o shows the target one cycle after adv.
- flush_i in the same cycle as branch_i or as a pending apply: flush wins and the branch is dropped.
- pend_o = (state == PEND), registered.

## Structure
- Shared cpu package holds: state enum (HOLD/RUN/PEND), default ADDR_W, RESET_VEC and STEP constants, and the `Branch`/`NoStop` polarity constants.
- Optional sub-module redirect_buf: one-entry target register with valid bit, plus load/clear. Everything else is a single always block for state/pc and a combinational next-PC mux.

## Test plan
- Reset then free run (gnt=1, stall=0, STEP=4, RESET_VEC=0x100): req rises 1 cycle after rst falls; pc_o = 0x100, 0x104, 0x108, one step per cycle.
- Branch while stalled: stall=1 at pc 0x108, branch_i to 0x2000:
  - pend_o=1 and pc_o held at 0x108.
  - stall drops → pc_o = 0x2000 next cycle, pend_o=0.
- Flush beats branch: flush_i to 0x80 and branch_i to 0x3000 together, with stall=1 → pc_o = 0x80 next cycle, no pending.
- Misaligned branch: branch_pc_i = 0x2002 with adv → pc_o = 0x2000 and misalign_o high for exactly one cycle.
- Wrap and grant gaps (ADDR_W=8, STEP=4):
  - pc_o = 0xFC, gnt=1 → 0x00.
  - gnt=0 for 3 cycles → pc_o holds.
- Reset mid-PEND: pending branch buffered, then rst=1 → pc_o = RESET_VEC, pend_o = 0, and after release fetch resumes from RESET_VEC.
